// File: rtl/vector_abs_stream.sv
// ---------------------------------------------------------------------------
// vector_abs_stream
//   Streaming magnitude estimate stage that sits after the max/min sorter.
//   Accepts (max, min) pairs over valid/ready and produces
//   |v| ~= max + (min >> 1) through a 2-stage pipeline. It also tracks the
//   peak estimate over fixed-length frames of output handshakes.
//
// Parameters
//   WIDTH      width of max_i / min_i; results are WIDTH+1 bits
//   FRAME_LEN  output handshakes per peak frame (>= 2)
//
// Ports
//   clk_i         clock, all state on rising edge
//   rst_i         asynchronous active-high reset
//   s_valid_i     upstream pair valid
//   s_ready_o     stage can take a pair this cycle
//   max_i/min_i   larger / smaller component from the sorter
//   m_valid_o     abs_o valid
//   m_ready_i     downstream accepts abs_o
//   abs_o         max + (min >> 1)
//   peak_o        largest abs_o of the last completed frame
//   frame_done_o  1-cycle pulse: peak_o was just updated
// ---------------------------------------------------------------------------
module vector_abs_stream #(
  parameter int WIDTH     = 32,
  parameter int FRAME_LEN = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] max_i,
  input  logic [WIDTH-1:0] min_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH:0]   abs_o,
  output logic [WIDTH:0]   peak_o,
  output logic             frame_done_o
);

  localparam int STAGES = 2;
  localparam int CW     = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] mx;
    logic [WIDTH-1:0] mn;
  } pair_t;

  // r_vld_pipe[1] = stage A holds a pair, r_vld_pipe[2] = abs_o valid
  logic [STAGES:1] r_vld_pipe;
  pair_t           r_a;
  logic [WIDTH:0]  r_abs;
  logic [WIDTH:0]  r_run;
  logic [WIDTH:0]  r_peak;
  logic [CW-1:0]   r_cnt;
  logic            r_done;

  logic            w_b_adv;
  logic            w_acc;
  logic            w_a2b;
  logic            w_ohs;
  logic            w_last;
  logic [WIDTH:0]  w_sum;
  logic [WIDTH:0]  w_new_run;

  // Stage B can take new data when it is empty or being drained this cycle;
  // stage A can take data when empty or moving into B. This lets accept,
  // A->B and the output handshake all happen on the same edge.
  assign w_b_adv   = !r_vld_pipe[2] | m_ready_i;
  assign s_ready_o = !r_vld_pipe[1] | w_b_adv;
  assign w_acc     = s_valid_i & s_ready_o;
  assign w_a2b     = r_vld_pipe[1] & w_b_adv;
  assign w_ohs     = r_vld_pipe[2] & m_ready_i;
  assign w_last    = (r_cnt == CW'(FRAME_LEN - 1));

  // Zero-extended unsigned add; WIDTH+1 bits cannot overflow.
  assign w_sum     = {1'b0, r_a.mx} + {1'b0, (r_a.mn >> 1)};
  assign w_new_run = (r_abs > r_run) ? r_abs : r_run;

  // Stage A: input pair register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_pipe[1] <= 1'b0;
      r_a           <= '0;
    end else if (w_acc) begin
      r_vld_pipe[1] <= 1'b1;
      r_a.mx        <= max_i;
      r_a.mn        <= min_i;
    end else if (w_a2b) begin
      r_vld_pipe[1] <= 1'b0;
    end
  end

  // Stage B: result register; data holds whenever B is not advancing
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld_pipe[2] <= 1'b0;
      r_abs         <= '0;
    end else if (w_a2b) begin
      r_vld_pipe[2] <= 1'b1;
      r_abs         <= w_sum;
    end else if (w_b_adv) begin
      r_vld_pipe[2] <= 1'b0;
    end
  end

  // Frame peak tracking on output handshakes. Only complete frames update
  // peak_o; the running peak is restarted at every frame boundary.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_run  <= '0;
      r_peak <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_ohs) begin
        if (w_last) begin
          r_peak <= w_new_run;
          r_run  <= '0;
          r_cnt  <= '0;
          r_done <= 1'b1;
        end else begin
          r_run  <= w_new_run;
          r_cnt  <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign m_valid_o    = r_vld_pipe[2];
  assign abs_o        = r_abs;
  assign peak_o       = r_peak;
  assign frame_done_o = r_done;

endmodule

// File: tb/tb_vector_abs_stream.sv
// ---------------------------------------------------------------------------
// tb_vector_abs_stream
//   Directed bench for vector_abs_stream: reset state, latency, full-scale
//   arithmetic, backpressure, frame peak, async reset mid-frame and a
//   scoreboarded random-backpressure stream.
// ---------------------------------------------------------------------------
module tb_vector_abs_stream;
  localparam int W  = 32;
  localparam int FL = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] mx;
  logic [W-1:0] mn;
  logic         m_valid;
  logic         m_ready;
  logic [W:0]   abs_v;
  logic [W:0]   peak;
  logic         fd;

  always #5 clk = ~clk;

  vector_abs_stream #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .max_i       (mx),
    .min_i       (mn),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .abs_o       (abs_v),
    .peak_o      (peak),
    .frame_done_o(fd)
  );

  int         total  = 0;
  int         bad    = 0;
  int         hs_cnt = 0;
  int         fd_cnt = 0;
  int         fd_at  = -1;
  int         cyc_cnt = 0;
  logic       last_acc;
  bit         rnd_rdy = 1'b0;
  logic [W:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes just before the edge, advance, then
  // look at frame_done_o 1 time unit after the edge.
  task automatic cyc();
    logic [W:0] e;
    if (rnd_rdy) m_ready = 1'($urandom_range(0, 1));
    #1;
    last_acc = s_valid & s_ready;
    if (last_acc) q.push_back({1'b0, mx} + {1'b0, (mn >> 1)});
    if (m_valid & m_ready) begin
      hs_cnt++;
      chk("sb_nonempty", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_abs", 64'(abs_v), 64'(e));
      end
    end
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (fd) begin
      fd_cnt++;
      fd_at = hs_cnt;
    end
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    s_valid = 1'b1;
    mx = a;
    mn = b;
    do begin
      cyc();
      n++;
    end while (!last_acc && n < 200);
    chk("push_acc", 64'(last_acc), 64'd1);
    s_valid = 1'b0;
  endtask

  task automatic drain(input int target);
    int n = 0;
    while (hs_cnt < target && n < 100) begin
      cyc();
      n++;
    end
    chk("drain_hs", 64'(hs_cnt), 64'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    q.delete();
    hs_cnt = 0;
    fd_cnt = 0;
    fd_at  = -1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] a, b, t;
    int base, c0, h0;
    rst = 1'b1; s_valid = 1'b0; mx = '0; mn = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_abs",    64'(abs_v),   64'd0);
    chk("rst_peak",   64'(peak),    64'd0);
    chk("rst_fd",     64'(fd),      64'd0);
    chk("rst_sready", 64'(s_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: single pair, 10 + 4/2 = 12, one cycle of valid
    m_ready = 1'b1;
    push(32'd10, 32'd4);
    chk("t1_not_yet", 64'(m_valid), 64'd0);
    cyc();
    chk("t1_valid", 64'(m_valid), 64'd1);
    chk("t1_abs",   64'(abs_v),   64'd12);
    cyc();
    chk("t1_drop",  64'(m_valid), 64'd0);
    chk("t1_hold",  64'(abs_v),   64'd12);

    // 2: full scale
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc();
    chk("t2_abs", 64'(abs_v), 64'h1_7FFF_FFFE);
    cyc();

    // 3: backpressure: two accepted, third blocked, then all three in order
    m_ready = 1'b0;
    push(32'd100, 32'd20);
    push(32'd200, 32'd40);
    chk("t3_sready", 64'(s_ready), 64'd0);
    chk("t3_abs0",   64'(abs_v),   64'd110);
    s_valid = 1'b1; mx = 32'd300; mn = 32'd60;
    repeat (3) begin
      cyc();
      chk("t3_noacc", 64'(last_acc), 64'd0);
      chk("t3_hold",  64'(abs_v),    64'd110);
    end
    base = hs_cnt;
    m_ready = 1'b1;
    cyc();
    chk("t3_acc", 64'(last_acc), 64'd1);
    s_valid = 1'b0;
    drain(base + 3);
    chk("t3_sb_empty", 64'(q.size()), 64'd0);
    cyc();
    chk("t3_idle", 64'(m_valid), 64'd0);

    // 4: frame peak 100, then a frame of all 7
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push((i == 5) ? 32'd100 : 32'(i), 32'd0);
    drain(15);
    chk("t4_peak_pre", 64'(peak),   64'd0);
    chk("t4_fd_pre",   64'(fd_cnt), 64'd0);
    drain(16);
    chk("t4_fd_now",   64'(fd),     64'd1);
    chk("t4_fd_at",    64'(fd_at),  64'd16);
    chk("t4_peak",     64'(peak),   64'd100);
    cyc();
    chk("t4_fd_pulse", 64'(fd),     64'd0);
    for (int i = 0; i < 16; i++) push(32'd6, 32'd2);
    drain(31);
    chk("t4_peak_hold", 64'(peak),   64'd100);
    chk("t4_fd_cnt1",   64'(fd_cnt), 64'd1);
    drain(32);
    chk("t4_peak7",     64'(peak),   64'd7);
    chk("t4_fd_cnt2",   64'(fd_cnt), 64'd2);

    // 5: async reset mid-frame while stalled
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) push(32'd4, 32'd2);
    drain(7);
    m_ready = 1'b0;
    push(32'd9, 32'd9);
    push(32'd9, 32'd9);
    chk("t5_stalled", 64'(m_valid), 64'd1);
    chk("t5_abs13",   64'(abs_v),   64'd13);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_mvalid", 64'(m_valid), 64'd0);
    chk("t5_rst_abs",    64'(abs_v),   64'd0);
    chk("t5_rst_peak",   64'(peak),    64'd0);
    chk("t5_rst_fd",     64'(fd),      64'd0);
    chk("t5_rst_sready", 64'(s_ready), 64'd1);
    rst = 1'b0;
    q.delete();
    hs_cnt = 0; fd_cnt = 0; fd_at = -1;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    for (int j = 1; j <= 16; j++) push(32'(j), 32'(j));
    drain(16);
    repeat (3) cyc();
    chk("t5_fd_at",  64'(fd_at),  64'd16);
    chk("t5_fd_cnt", 64'(fd_cnt), 64'd1);
    chk("t5_peak",   64'(peak),   64'd24);

    // 6: random backpressure stream, then full-rate throughput
    rnd_rdy = 1'b1;
    base = hs_cnt;
    for (int k = 0; k < 100; k++) begin
      a = $urandom;
      b = $urandom;
      if (b > a) begin t = a; a = b; b = t; end
      push(a, b);
    end
    drain(base + 100);
    rnd_rdy = 1'b0;
    m_ready = 1'b1;
    chk("t6_sb_empty", 64'(q.size()), 64'd0);
    c0 = cyc_cnt;
    h0 = hs_cnt;
    for (int k = 0; k < 20; k++) push(32'(k * 3 + 1), 32'(k));
    chk("t6_cycles", 64'(cyc_cnt - c0), 64'd20);
    chk("t6_hs_rate", 64'(hs_cnt - h0), 64'd18);
    drain(h0 + 20);
    chk("t6_sb_empty2", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
